// File: rtl/sram_mp_arb_if.sv
// -----------------------------------------------------------------------------
// sram_mp_arb_if
//   Request/grant/response bundle between NPORTS masters and sram_mp_arb.
//   Per-port fields are flattened: port i occupies slice i of each vector.
//
//   req    [NPORTS]          access request, held until granted
//   we     [NPORTS]          1 = write, 0 = read
//   waddr  [NPORTS*WORD_AW]  word address
//   din    [NPORTS*DW]       write data
//   sel    [NPORTS*SW]       byte enables, bit b covers din[8b+7:8b]
//   gnt    [NPORTS]          one-hot grant, access commits at this edge
//   rvalid [NPORTS]          read data valid for port i
//   rerr   [NPORTS]          read error, qualified by rvalid
//   rdata  [DW]              shared read data, qualified by rvalid
//
//   modport master : drives the request side (bus adapters, testbench)
//   modport slave  : drives grant and response (the memory)
// -----------------------------------------------------------------------------
interface sram_mp_arb_if #(
    parameter int NPORTS = 2,
    parameter int AW     = 32,
    parameter int DW     = 32
);
    localparam int SW      = DW / 8;
    localparam int WORD_AW = AW - $clog2(SW);

    logic [NPORTS-1:0]         req;
    logic [NPORTS-1:0]         we;
    logic [NPORTS*WORD_AW-1:0] waddr;
    logic [NPORTS*DW-1:0]      din;
    logic [NPORTS*SW-1:0]      sel;
    logic [NPORTS-1:0]         gnt;
    logic [NPORTS-1:0]         rvalid;
    logic [NPORTS-1:0]         rerr;
    logic [DW-1:0]             rdata;

    modport master (
        output req, we, waddr, din, sel,
        input  gnt, rvalid, rerr, rdata
    );

    modport slave (
        input  req, we, waddr, din, sel,
        output gnt, rvalid, rerr, rdata
    );
endinterface

// File: rtl/sram_mp_arb.sv
// -----------------------------------------------------------------------------
// sram_mp_arb
//   Multi-port byte-addressable SRAM. A round-robin arbiter commits one access
//   per cycle from NPORTS masters to a single storage array; read data returns
//   RD_LAT cycles after the grant, tagged with the requesting port.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset (array contents are kept)
//     bus    sram_mp_arb_if.slave: req/we/waddr/din/sel in,
//            gnt/rvalid/rerr/rdata out
//
//   Optional feature (compile-time macro OPTIMSOC_SRAM_BOUNDS_CHECK_EN):
//     defined   - waddr >= DEPTH is granted but a write is dropped and a read
//                 returns rdata = 0 with rerr = 1 at the normal latency.
//     undefined - only the low clog2(DEPTH) address bits are used, so
//                 out-of-range addresses alias; rerr stays 0.
//
//   MEM_FILE names the hex preload image used by simulation environments that
//   initialise the array contents.
// -----------------------------------------------------------------------------
module sram_mp_arb #(
    parameter int    NPORTS        = 2,
    parameter int    AW            = 32,
    parameter int    DW            = 32,
    parameter int    MEM_SIZE_BYTE = 32768,
    parameter int    RD_LAT        = 1,
    parameter string MEM_FILE      = "sram.vmem"
) (
    input  logic         clk,
    input  logic         rst_n,
    sram_mp_arb_if.slave bus
);
    localparam int SW      = DW / 8;
    localparam int WORD_AW = AW - $clog2(SW);
    localparam int DEPTH   = MEM_SIZE_BYTE / SW;
    localparam int IDXW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW      = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int LAST    = RD_LAT - 1;

    // ------------------------------------------------------------------
    // Round-robin arbiter: rotate the request vector so that bit 0 is the
    // port at ptr, pick the first set bit, then map back to a port index.
    // ------------------------------------------------------------------
    logic [PW-1:0]       ptr;
    logic [PW-1:0]       win;
    logic                any_req;
    logic [NPORTS-1:0]   req_rot;
    logic [2*NPORTS-1:0] req_dbl;
    logic [NPORTS-1:0]   gnt;

    assign req_dbl = {bus.req, bus.req};
    assign req_rot = NPORTS'(req_dbl >> ptr);

    // NOTE: every variable driven in a combinational block gets a default
    // before any conditional assignment, otherwise a latch is inferred.
    always_comb begin
        win     = '0;
        any_req = 1'b0;
        for (int k = 0; k < NPORTS; k++) begin
            if (!any_req && req_rot[k]) begin
                any_req = 1'b1;
                win     = PW'(((int'(ptr) + k) >= NPORTS) ? (int'(ptr) + k - NPORTS)
                                                          : (int'(ptr) + k));
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (any_req) begin
            gnt[win] = 1'b1;
        end
    end

    assign bus.gnt = gnt;

    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (any_req) begin
            ptr <= (win == PW'(NPORTS - 1)) ? '0 : win + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Granted access mux
    // ------------------------------------------------------------------
    logic               g_we;
    logic [WORD_AW-1:0] g_addr;
    logic [DW-1:0]      g_din;
    logic [SW-1:0]      g_sel;
    logic [IDXW-1:0]    g_idx;
    logic               g_oob;
    logic               wr_en;
    logic               rd_en;

    assign g_we   = bus.we[win];
    assign g_addr = bus.waddr[int'(win)*WORD_AW +: WORD_AW];
    assign g_din  = bus.din[int'(win)*DW +: DW];
    assign g_sel  = bus.sel[int'(win)*SW +: SW];
    assign g_idx  = g_addr[IDXW-1:0];

`ifdef OPTIMSOC_SRAM_BOUNDS_CHECK_EN
    assign g_oob = (64'(g_addr) >= 64'(DEPTH));
`else
    assign g_oob = 1'b0;
`endif

    assign wr_en = any_req &&  g_we && !g_oob;
    assign rd_en = any_req && !g_we;

    // ------------------------------------------------------------------
    // Storage array
    // ------------------------------------------------------------------
    logic [DW-1:0] mem [DEPTH];

    // NOTE: the array has no reset: contents survive rst_n, and a reset on a
    // RAM would prevent mapping it onto a memory macro.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < SW; b++) begin
                if (g_sel[b]) begin
                    mem[g_idx][8*b +: 8] <= g_din[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline: stage 0 captures the array at the grant edge, the last
    // stage drives the outputs. Data/port/err only advance alongside a valid,
    // so the last stage keeps the previous rdata during bubbles.
    // ------------------------------------------------------------------
    logic [RD_LAT-1:0] p_vld;
    logic [RD_LAT-1:0] p_err;
    logic [PW-1:0]     p_port [RD_LAT];
    logic [DW-1:0]     p_data [RD_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_vld <= '0;
            p_err <= '0;
            for (int s = 0; s < RD_LAT; s++) begin
                p_port[s] <= '0;
                p_data[s] <= '0;
            end
        end else begin
            p_vld[0] <= rd_en;
            if (rd_en) begin
                p_port[0] <= win;
                p_data[0] <= g_oob ? '0 : mem[g_idx];
                p_err[0]  <= g_oob;
            end
            for (int s = 1; s < RD_LAT; s++) begin
                p_vld[s] <= p_vld[s-1];
                if (p_vld[s-1]) begin
                    p_port[s] <= p_port[s-1];
                    p_data[s] <= p_data[s-1];
                    p_err[s]  <= p_err[s-1];
                end
            end
        end
    end

    logic [NPORTS-1:0] rvalid;
    logic [NPORTS-1:0] rerr;

    always_comb begin
        rvalid = '0;
        rerr   = '0;
        if (p_vld[LAST]) begin
            rvalid[p_port[LAST]] = 1'b1;
            rerr[p_port[LAST]]   = p_err[LAST];
        end
    end

    assign bus.rvalid = rvalid;
    assign bus.rerr   = rerr;
    assign bus.rdata  = p_data[LAST];
endmodule

// File: tb/tb_sram_mp_arb.sv
// -----------------------------------------------------------------------------
// tb_sram_mp_arb
//   Drives sram_mp_arb (3 ports, RD_LAT = 3) through directed scenarios and a
//   randomized phase. A reference model holds the array as plain words, the
//   round-robin rule as an integer pointer, and outstanding reads as a queue
//   of {port, data, err, due-edge}. Inputs change on the falling edge; gnt is
//   sampled 1 ns later, responses on the next falling edge.
// -----------------------------------------------------------------------------
module tb_sram_mp_arb;
    localparam int NP       = 3;
    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int SW       = DW / 8;
    localparam int WAW      = AW - $clog2(SW);
    localparam int MEM_SIZE = 1024;
    localparam int DEPTH    = MEM_SIZE / SW;
    localparam int RD_LAT   = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_mp_arb_if #(.NPORTS(NP), .AW(AW), .DW(DW)) bus ();

    sram_mp_arb #(
        .NPORTS(NP), .AW(AW), .DW(DW),
        .MEM_SIZE_BYTE(MEM_SIZE), .RD_LAT(RD_LAT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        int            port;
        logic [DW-1:0] data;
        bit            err;
        int            due;
    } rd_exp_t;

    int            checks   = 0;
    int            errors   = 0;
    int            edge_cnt = 0;
    int            ptr_m    = 0;
    int            last_win = -1;
    logic [DW-1:0] mem_m [DEPTH];
    logic [DW-1:0] rdata_m  = '0;
    logic [NP-1:0] gnt_seen = '0;
    rd_exp_t       exp_q[$];

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic idle_inputs();
        bus.req   = '0;
        bus.we    = '0;
        bus.waddr = '0;
        bus.din   = '0;
        bus.sel   = '0;
    endtask

    task automatic drive(input int p, input bit r, input bit w, input int unsigned a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
        bus.req[p]                = r;
        bus.we[p]                 = w;
        bus.waddr[p*WAW +: WAW]   = WAW'(a);
        bus.din[p*DW +: DW]       = d;
        bus.sel[p*SW +: SW]       = s;
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic int model_winner();
        for (int k = 0; k < NP; k++) begin
            if (bus.req[(ptr_m + k) % NP]) return (ptr_m + k) % NP;
        end
        return -1;
    endfunction

    task automatic model_commit(input int w);
        int unsigned   a;
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        bit            oob;
        int            idx;
        rd_exp_t       e;
        a   = int'(bus.waddr[w*WAW +: WAW]);
        d   = bus.din[w*DW +: DW];
        s   = bus.sel[w*SW +: SW];
        oob = 1'b0;
`ifdef OPTIMSOC_SRAM_BOUNDS_CHECK_EN
        oob = (a >= DEPTH);
`endif
        idx = int'(a % DEPTH);
        if (bus.we[w]) begin
            if (!oob) begin
                for (int b = 0; b < SW; b++) begin
                    if (s[b]) mem_m[idx][8*b +: 8] = d[8*b +: 8];
                end
            end
        end else begin
            e.port = w;
            e.data = oob ? '0 : mem_m[idx];
            e.err  = oob;
            e.due  = edge_cnt + RD_LAT - 1;
            exp_q.push_back(e);
        end
        ptr_m = (w + 1) % NP;
    endtask

    task automatic check_resp();
        logic [NP-1:0] ev;
        logic [NP-1:0] ee;
        rd_exp_t       e;
        ev = '0;
        ee = '0;
        if (exp_q.size() > 0 && exp_q[0].due == edge_cnt) begin
            e = exp_q.pop_front();
            ev[e.port] = 1'b1;
            ee[e.port] = e.err;
            rdata_m    = e.data;
        end
        checks++;
        if (bus.rvalid !== ev) begin
            errors++;
            $display("FAIL rvalid edge %0d: got %b want %b", edge_cnt, bus.rvalid, ev);
        end
        checks++;
        if (bus.rerr !== ee) begin
            errors++;
            $display("FAIL rerr edge %0d: got %b want %b", edge_cnt, bus.rerr, ee);
        end
        checks++;
        if (bus.rdata !== rdata_m) begin
            errors++;
            $display("FAIL rdata edge %0d: got %h want %h", edge_cnt, bus.rdata, rdata_m);
        end
    endtask

    // One clock: check gnt against the model, commit at the edge, check responses.
    task automatic cycle();
        int            w;
        logic [NP-1:0] exp_gnt;
        #1;
        w        = model_winner();
        exp_gnt  = (w >= 0) ? (NP'(1) << w) : '0;
        gnt_seen = bus.gnt;
        checks++;
        if (bus.gnt !== exp_gnt) begin
            errors++;
            $display("FAIL gnt edge %0d: got %b want %b", edge_cnt + 1, bus.gnt, exp_gnt);
        end
        last_win = w;
        @(posedge clk);
        edge_cnt++;
        if (w >= 0) model_commit(w);
        @(negedge clk);
        check_resp();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        exp_q.delete();
        ptr_m   = 0;
        rdata_m = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Idle until rvalid[p] shows up, bounded by max_cyc clocks.
    task automatic drain_wait(input string name, input int p, input int max_cyc,
                              output bit found, output logic [DW-1:0] d, output int at);
        found = 1'b0;
        d     = '0;
        at    = -1;
        if (bus.rvalid[p] === 1'b1) begin
            found = 1'b1;
            d     = bus.rdata;
            at    = edge_cnt;
        end
        for (int i = 0; i < max_cyc && !found; i++) begin
            idle_inputs();
            cycle();
            if (bus.rvalid[p] === 1'b1) begin
                found = 1'b1;
                d     = bus.rdata;
                at    = edge_cnt;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s: rvalid[%0d] got none within %0d cycles want one", name, p, max_cyc);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            idle_inputs();
            cycle();
        end
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.gnt !== '0 || bus.rvalid !== '0 || bus.rerr !== '0 || bus.rdata !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got gnt=%b rvalid=%b rerr=%b rdata=%h want all 0",
                     bus.gnt, bus.rvalid, bus.rerr, bus.rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(3);
    endtask

    task automatic test_prefill();
        for (int i = 0; i < DEPTH; i++) begin
            idle_inputs();
            drive(i % NP, 1'b1, 1'b1, i, $urandom, '1);
            cycle();
        end
        idle_cycles(1);
    endtask

    task automatic test_byte_mask();
        bit            found;
        logic [DW-1:0] d;
        int            at;
        int            g;
        idle_inputs(); drive(0, 1'b1, 1'b1, 5, 32'hAABBCCDD, 4'hF);    cycle();
        idle_inputs(); drive(0, 1'b1, 1'b1, 5, 32'h11223344, 4'b0101); cycle();
        idle_inputs(); drive(0, 1'b1, 1'b0, 5, '0, 4'h0);              cycle();
        g = edge_cnt;
        drain_wait("byte_mask", 0, RD_LAT + 4, found, d, at);
        if (found) begin
            checks++;
            if (d !== 32'hAA22CC44) begin
                errors++;
                $display("FAIL byte_mask_data: got %h want %h", d, 32'hAA22CC44);
            end
            checks++;
            if (at - g + 1 != RD_LAT) begin
                errors++;
                $display("FAIL byte_mask_latency: got %0d want %0d", at - g + 1, RD_LAT);
            end
        end
        idle_cycles(2);
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int c = 0; c < 2 * NP; c++) begin
            for (int p = 0; p < NP; p++) drive(p, 1'b1, 1'b0, $urandom_range(0, DEPTH - 1), '0, '0);
            cycle();
            checks++;
            if (gnt_seen !== (NP'(1) << (c % NP))) begin
                errors++;
                $display("FAIL rr_all step %0d: got %b want %b", c, gnt_seen, NP'(1) << (c % NP));
            end
        end
        idle_cycles(RD_LAT + 1);
        do_reset();
        drive(1, 1'b1, 1'b0, 1, '0, '0);
        drive(2, 1'b1, 1'b0, 2, '0, '0);
        cycle();
        checks++;
        if (gnt_seen !== 3'b010) begin
            errors++;
            $display("FAIL rr_skip_first: got %b want %b", gnt_seen, 3'b010);
        end
        drive(1, 1'b0, 1'b0, 0, '0, '0);
        cycle();
        checks++;
        if (gnt_seen !== 3'b100) begin
            errors++;
            $display("FAIL rr_skip_second: got %b want %b", gnt_seen, 3'b100);
        end
        idle_cycles(RD_LAT + 1);
    endtask

    task automatic test_back_to_back();
        int            first;
        int            seen[$];
        logic [DW-1:0] dseen[$];
        first = 0;
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            drive(1, 1'b1, 1'b0, i, '0, '0);
            cycle();
            if (i == 0) first = edge_cnt;
            if (bus.rvalid[1] === 1'b1) begin seen.push_back(edge_cnt); dseen.push_back(bus.rdata); end
        end
        for (int i = 0; i < RD_LAT + 2; i++) begin
            idle_inputs();
            cycle();
            if (bus.rvalid[1] === 1'b1) begin seen.push_back(edge_cnt); dseen.push_back(bus.rdata); end
        end
        checks++;
        if (seen.size() != 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d want 4", seen.size());
        end else begin
            checks++;
            if (seen[0] != first + RD_LAT - 1 || seen[3] != seen[0] + 3) begin
                errors++;
                $display("FAIL b2b_timing: got first=%0d last=%0d want first=%0d last=%0d",
                         seen[0], seen[3], first + RD_LAT - 1, first + RD_LAT + 2);
            end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (dseen[i] !== mem_m[i]) begin
                    errors++;
                    $display("FAIL b2b_data word %0d: got %h want %h", i, dseen[i], mem_m[i]);
                end
            end
        end
    endtask

    task automatic test_write_read_order();
        bit            found;
        logic [DW-1:0] d;
        int            at;
        idle_inputs(); drive(0, 1'b1, 1'b1, 7, 32'hDEADBEEF, '1); cycle();
        idle_inputs(); drive(1, 1'b1, 1'b0, 7, '0, '0);            cycle();
        checks++;
        if (gnt_seen !== 3'b010) begin
            errors++;
            $display("FAIL wr_rd_gnt: got %b want %b", gnt_seen, 3'b010);
        end
        drain_wait("wr_rd_order", 1, RD_LAT + 4, found, d, at);
        if (found) begin
            checks++;
            if (d !== 32'hDEADBEEF) begin
                errors++;
                $display("FAIL wr_rd_data: got %h want %h", d, 32'hDEADBEEF);
            end
        end
        idle_cycles(2);
    endtask

    task automatic test_bounds();
        bit            found;
        logic [DW-1:0] d;
        int            at;
`ifdef OPTIMSOC_SRAM_BOUNDS_CHECK_EN
        logic [DW-1:0] w0;
        idle_inputs(); drive(2, 1'b1, 1'b0, DEPTH, '0, '0); cycle();
        drain_wait("oob_read", 2, RD_LAT + 4, found, d, at);
        if (found) begin
            checks++;
            if (d !== '0 || bus.rerr[2] !== 1'b1) begin
                errors++;
                $display("FAIL oob_read: got rdata=%h rerr=%b want rdata=0 rerr=1", d, bus.rerr[2]);
            end
        end
        w0 = mem_m[0];
        idle_inputs(); drive(2, 1'b1, 1'b1, DEPTH, 32'h5A5A5A5A, '1); cycle();
        idle_inputs(); drive(2, 1'b1, 1'b0, 0, '0, '0);                cycle();
        drain_wait("oob_write", 2, RD_LAT + 4, found, d, at);
        if (found) begin
            checks++;
            if (d !== w0) begin
                errors++;
                $display("FAIL oob_write_word0: got %h want %h", d, w0);
            end
        end
`else
        logic [DW-1:0] w0;
        w0 = mem_m[0];
        idle_inputs(); drive(2, 1'b1, 1'b0, DEPTH, '0, '0); cycle();
        drain_wait("alias_read", 2, RD_LAT + 4, found, d, at);
        if (found) begin
            checks++;
            if (d !== w0 || bus.rerr[2] !== 1'b0) begin
                errors++;
                $display("FAIL alias_read: got rdata=%h rerr=%b want rdata=%h rerr=0", d, bus.rerr[2], w0);
            end
        end
        idle_inputs(); drive(2, 1'b1, 1'b1, DEPTH + 3, 32'h5A5A5A5A, '1); cycle();
        idle_inputs(); drive(2, 1'b1, 1'b0, 3, '0, '0);                    cycle();
        drain_wait("alias_write", 2, RD_LAT + 4, found, d, at);
        if (found) begin
            checks++;
            if (d !== 32'h5A5A5A5A) begin
                errors++;
                $display("FAIL alias_write_word3: got %h want %h", d, 32'h5A5A5A5A);
            end
        end
`endif
        idle_cycles(2);
    endtask

    task automatic test_reset_inflight();
        int            hits;
        bit            found;
        logic [DW-1:0] d;
        int            at;
        hits = 0;
        idle_inputs(); drive(0, 1'b1, 1'b1, 12, 32'hC0FFEE01, '1); cycle();
        idle_inputs(); drive(0, 1'b1, 1'b0, 10, '0, '0);          cycle();
        idle_inputs(); drive(1, 1'b1, 1'b0, 11, '0, '0);          cycle();
        rst_n = 1'b0;
        idle_inputs();
        exp_q.delete();
        ptr_m   = 0;
        rdata_m = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.rvalid !== '0) hits++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < RD_LAT + 2; i++) begin
            cycle();
            if (bus.rvalid !== '0) hits++;
        end
        checks++;
        if (hits != 0) begin
            errors++;
            $display("FAIL reset_inflight: got %0d rvalid cycles want 0", hits);
        end
        idle_inputs(); drive(2, 1'b1, 1'b0, 12, '0, '0); cycle();
        drain_wait("reset_keeps_mem", 2, RD_LAT + 4, found, d, at);
        if (found) begin
            checks++;
            if (d !== 32'hC0FFEE01) begin
                errors++;
                $display("FAIL reset_keeps_mem: got %h want %h", d, 32'hC0FFEE01);
            end
        end
        idle_cycles(2);
    endtask

    function automatic int unsigned rand_addr();
        if ($urandom_range(0, 99) < 85) return $urandom_range(0, 15);
        return $urandom_range(0, 2 * DEPTH - 1);
    endfunction

    task automatic test_random();
        bit pend [NP];
        for (int p = 0; p < NP; p++) pend[p] = 1'b0;
        idle_inputs();
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < NP; p++) begin
                if ((!pend[p] && $urandom_range(0, 99) < 55) ||
                    ( pend[p] && $urandom_range(0, 99) < 5)) begin
                    pend[p] = 1'b1;
                    drive(p, 1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom, SW'($urandom));
                end
            end
            cycle();
            if (last_win >= 0) begin
                pend[last_win] = 1'b0;
                drive(last_win, 1'b0, 1'b0, 0, '0, '0);
            end
        end
        idle_cycles(RD_LAT + 2);
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_prefill();
        test_byte_mask();
        test_round_robin();
        test_back_to_back();
        test_write_read_order();
        test_bounds();
        test_reset_inflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
